// File: rtl/chip8_mem_arbiter.sv
// Shares the single CHIP-8 byte memory port between the ROM loader, processor and sprite engine.
// Define CHIP8_ARB_RR_EN for processor/sprite round-robin; the loader always keeps top priority.
module chip8_mem_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              ld_req_in,
    input  logic [ADDR_W-1:0] ld_addr_in,
    input  logic [DATA_W-1:0] ld_wdata_in,
    output logic              ld_gnt_out,
    input  logic              pr_req_in,
    input  logic              pr_we_in,
    input  logic [ADDR_W-1:0] pr_addr_in,
    input  logic [DATA_W-1:0] pr_wdata_in,
    output logic              pr_gnt_out,
    output logic              pr_rvalid_out,
    output logic [DATA_W-1:0] pr_rdata_out,
    input  logic              sp_req_in,
    input  logic [ADDR_W-1:0] sp_addr_in,
    output logic              sp_gnt_out,
    output logic              sp_rvalid_out,
    output logic [DATA_W-1:0] sp_rdata_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in
);
    localparam logic [1:0] ID_LD = 2'd0;
    localparam logic [1:0] ID_PR = 2'd1;
    localparam logic [1:0] ID_SP = 2'd2;

    logic              ld_win, pr_win, sp_win, low_ok, prefer_sp;
    logic              iss_vld;
    logic [1:0]        iss_id;
    logic              vld_p [READ_LATENCY];
    logic [1:0]        id_p  [READ_LATENCY];
    logic              pr_hit, sp_hit;
    logic [DATA_W-1:0] pr_hold, sp_hold;

`ifdef CHIP8_ARB_RR_EN
    // Points at the requester that lost the last PR/SP grant; reset favours PR.
    logic rr_sp;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_sp <= 1'b0;
        end else if (pr_win) begin
            rr_sp <= 1'b1;
        end else if (sp_win) begin
            rr_sp <= 1'b0;
        end
    end

    assign prefer_sp = rr_sp;
`else
    assign prefer_sp = 1'b0;
`endif

    always_comb begin
        low_ok = rst_n_in && !ld_req_in;
        ld_win = rst_n_in && ld_req_in;
        pr_win = low_ok && pr_req_in && !(sp_req_in && prefer_sp);
        sp_win = low_ok && sp_req_in && (!pr_req_in || prefer_sp);
    end

    assign ld_gnt_out = ld_win;
    assign pr_gnt_out = pr_win;
    assign sp_gnt_out = sp_win;

    always_comb begin
        mem_en_out    = ld_win || pr_win || sp_win;
        mem_we_out    = ld_win || (pr_win && pr_we_in);
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        if (ld_win) begin
            mem_addr_out  = ld_addr_in;
            mem_wdata_out = ld_wdata_in;
        end else if (pr_win) begin
            mem_addr_out  = pr_addr_in;
            mem_wdata_out = pr_we_in ? pr_wdata_in : '0;
        end else if (sp_win) begin
            mem_addr_out  = sp_addr_in;
        end
        iss_vld = (pr_win && !pr_we_in) || sp_win;
        iss_id  = sp_win ? ID_SP : ID_PR;
    end

    // Issue stage -> read-return tag pipe; writes enter as bubbles
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                vld_p[s] <= 1'b0;
                id_p[s]  <= ID_LD;
            end
        end else begin
            vld_p[0] <= iss_vld;
            id_p[0]  <= iss_id;
            for (int s = 1; s < READ_LATENCY; s++) begin
                vld_p[s] <= vld_p[s-1];
                id_p[s]  <= id_p[s-1];
            end
        end
    end

    // Pipe tail lines up with BRAM data; the byte is shown on the pulse and held afterwards
    assign pr_hit = vld_p[READ_LATENCY-1] && (id_p[READ_LATENCY-1] == ID_PR);
    assign sp_hit = vld_p[READ_LATENCY-1] && (id_p[READ_LATENCY-1] == ID_SP);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pr_hold <= '0;
            sp_hold <= '0;
        end else begin
            if (pr_hit) pr_hold <= mem_rdata_in;
            if (sp_hit) sp_hold <= mem_rdata_in;
        end
    end

    assign pr_rvalid_out = pr_hit;
    assign sp_rvalid_out = sp_hit;
    assign pr_rdata_out  = pr_hit ? mem_rdata_in : pr_hold;
    assign sp_rdata_out  = sp_hit ? mem_rdata_in : sp_hold;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: BRAM model plus a transaction-level reference (shadow memory,
// ordered return queue, grant rule). Build with CHIP8_ARB_RR_EN to check the round-robin variant.
`timescale 1ns/1ps
module tb_chip8_mem_arbiter;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ld_req, pr_req, pr_we, sp_req;
    logic [11:0] ld_addr, pr_addr, sp_addr;
    logic [7:0]  ld_wdata, pr_wdata;
    logic        ld_gnt, pr_gnt, sp_gnt, pr_rvalid, sp_rvalid;
    logic [7:0]  pr_rdata, sp_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    chip8_mem_arbiter #(.READ_LATENCY(L), .ADDR_W(12), .DATA_W(8)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .ld_req_in(ld_req), .ld_addr_in(ld_addr), .ld_wdata_in(ld_wdata), .ld_gnt_out(ld_gnt),
        .pr_req_in(pr_req), .pr_we_in(pr_we), .pr_addr_in(pr_addr), .pr_wdata_in(pr_wdata),
        .pr_gnt_out(pr_gnt), .pr_rvalid_out(pr_rvalid), .pr_rdata_out(pr_rdata),
        .sp_req_in(sp_req), .sp_addr_in(sp_addr), .sp_gnt_out(sp_gnt),
        .sp_rvalid_out(sp_rvalid), .sp_rdata_out(sp_rdata),
        .mem_en_out(mem_en), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
        .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata)
    );

    function automatic logic [7:0] init_byte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    // BRAM with L-cycle read latency
    logic [7:0] bram    [4096];
    bit         written [4096];
    logic [7:0] rpipe   [L];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bram[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        rpipe[0] <= written[mem_addr] ? bram[mem_addr] : init_byte(mem_addr);
        for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[L-1];

    // Reference model
    typedef struct { int due; int id; logic [7:0] d; } ret_t;
    ret_t       retq[$];
    logic [7:0] shadow [4096];
    bit         m_rr;
    int         cyc;
    logic [7:0] m_pr_hold, m_sp_hold;
    logic [2:0] exp_gnt;
    logic       exp_pr_rv, exp_sp_rv;
    logic [7:0] exp_pr_rd, exp_sp_rd;
    int         checks, errors;

    function automatic logic [2:0] model_gnt();
        if (!rst_n) return 3'b000;
        if (ld_req) return 3'b100;
        if (pr_req && sp_req) begin
`ifdef CHIP8_ARB_RR_EN
            return m_rr ? 3'b001 : 3'b010;
`else
            return 3'b010;
`endif
        end
        return {1'b0, pr_req, sp_req};
    endfunction

    function automatic void model_expect();
        exp_gnt   = model_gnt();
        exp_pr_rv = 1'b0;
        exp_sp_rv = 1'b0;
        exp_pr_rd = m_pr_hold;
        exp_sp_rd = m_sp_hold;
        if (retq.size() > 0 && retq[0].due == cyc) begin
            if (retq[0].id == 1) begin exp_pr_rv = 1'b1; exp_pr_rd = retq[0].d; end
            else                 begin exp_sp_rv = 1'b1; exp_sp_rd = retq[0].d; end
        end
    endfunction

    function automatic void model_commit();
        logic [2:0] g;
        g = model_gnt();
        if (retq.size() > 0 && retq[0].due == cyc) begin
            if (retq[0].id == 1) m_pr_hold = retq[0].d;
            else                 m_sp_hold = retq[0].d;
            void'(retq.pop_front());
        end
        if (g[2]) begin
            shadow[ld_addr] = ld_wdata;
        end else if (g[1]) begin
            if (pr_we) shadow[pr_addr] = pr_wdata;
            else retq.push_back('{due: cyc + L, id: 1, d: shadow[pr_addr]});
            m_rr = 1'b1;
        end else if (g[0]) begin
            retq.push_back('{due: cyc + L, id: 2, d: shadow[sp_addr]});
            m_rr = 1'b0;
        end
        cyc++;
    endfunction

    function automatic void model_reset();
        retq.delete();
        m_rr      = 1'b0;
        m_pr_hold = 8'h00;
        m_sp_hold = 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_commit();
        #1;
    endtask

    task automatic idle();
        ld_req = 1'b0; pr_req = 1'b0; sp_req = 1'b0;
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 7));
        return 12'hFFF - 12'($urandom_range(0, 3));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; idle(); model_reset();
        repeat (2) @(negedge clk);
        checks++; if ({ld_gnt, pr_gnt, sp_gnt} !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", {ld_gnt, pr_gnt, sp_gnt}); end
        checks++; if ({pr_rvalid, sp_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {pr_rvalid, sp_rvalid}); end
        checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_en, mem_we}); end
        checks++; if ({mem_addr, mem_wdata} !== 20'h0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
        checks++; if ({pr_rdata, sp_rdata} !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {pr_rdata, sp_rdata}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_three_way();
        logic [11:0] pa, sa;
        logic [2:0]  want;
        pa = 12'h400 | 12'($urandom_range(0, 255));
        sa = 12'h600 | 12'($urandom_range(0, 255));
        ld_req = 1'b1; ld_addr = 12'h700; ld_wdata = 8'($urandom);
        pr_req = 1'b1; pr_we = 1'b0; pr_addr = pa;
        sp_req = 1'b1; sp_addr = sa;
        for (int c = 0; c < 4 + L; c++) begin
            @(negedge clk);
            want = (c < 3) ? (3'b100 >> c) : 3'b000;
            checks++; if ({ld_gnt, pr_gnt, sp_gnt} !== want) begin errors++; $display("FAIL three_way_gnt c%0d: got %b want %b", c, {ld_gnt, pr_gnt, sp_gnt}, want); end
            checks++; if (pr_rvalid !== (c == 1 + L)) begin errors++; $display("FAIL three_way_pr_rvalid c%0d: got %b", c, pr_rvalid); end
            checks++; if (sp_rvalid !== (c == 2 + L)) begin errors++; $display("FAIL three_way_sp_rvalid c%0d: got %b", c, sp_rvalid); end
            if (c == 1 + L) begin
                checks++; if (pr_rdata !== shadow[pa]) begin errors++; $display("FAIL three_way_pr_data: got %h want %h", pr_rdata, shadow[pa]); end
            end
            if (c == 2 + L) begin
                checks++; if (sp_rdata !== shadow[sa]) begin errors++; $display("FAIL three_way_sp_data: got %h want %h", sp_rdata, shadow[sa]); end
            end
            tick();
            if (c == 0) ld_req = 1'b0;
            if (c == 1) pr_req = 1'b0;
            if (c == 2) sp_req = 1'b0;
        end
    endtask

    task automatic test_ld_pr();
        ld_req = 1'b1; ld_addr = 12'h200; ld_wdata = 8'hAB;
        @(negedge clk);
        checks++; if ({ld_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 12'h200, 8'hAB}) begin errors++; $display("FAIL ld_write: got gnt=%b en=%b we=%b a=%h d=%h", ld_gnt, mem_en, mem_we, mem_addr, mem_wdata); end
        tick();
        ld_req = 1'b0;
        pr_req = 1'b1; pr_we = 1'b0; pr_addr = 12'h200;
        @(negedge clk);
        checks++; if ({pr_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 12'h200}) begin errors++; $display("FAIL pr_read_issue: got gnt=%b en=%b we=%b a=%h", pr_gnt, mem_en, mem_we, mem_addr); end
        tick();
        pr_req = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            checks++; if (pr_rvalid !== (k == L)) begin errors++; $display("FAIL ld_pr_rvalid k%0d: got %b", k, pr_rvalid); end
            if (k >= L) begin
                checks++; if (pr_rdata !== 8'hAB) begin errors++; $display("FAIL ld_pr_rdata k%0d: got %h want ab", k, pr_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_sp_burst();
        logic e;
        sp_req = 1'b1;
        for (int c = 0; c < 6 + L; c++) begin
            if (c < 5) sp_addr = 12'(12'h050 + c);
            else       sp_req = 1'b0;
            @(negedge clk);
            checks++; if (sp_gnt !== (c < 5)) begin errors++; $display("FAIL sp_burst_gnt c%0d: got %b", c, sp_gnt); end
            e = (c >= L) && (c < 5 + L);
            checks++; if (sp_rvalid !== e) begin errors++; $display("FAIL sp_burst_rvalid c%0d: got %b want %b", c, sp_rvalid, e); end
            if (e) begin
                checks++; if (sp_rdata !== shadow[12'(12'h050 + c - L)]) begin errors++; $display("FAIL sp_burst_data c%0d: got %h want %h", c, sp_rdata, shadow[12'(12'h050 + c - L)]); end
            end
            tick();
        end
    endtask

    task automatic test_pr_wr_rd();
        pr_req = 1'b1; pr_we = 1'b1; pr_addr = 12'h300; pr_wdata = 8'h12;
        for (int c = 0; c < 3 + L; c++) begin
            if (c == 1) pr_we = 1'b0;
            if (c >= 2) begin pr_req = 1'b0; pr_we = 1'b1; end
            @(negedge clk);
            checks++; if (pr_gnt !== (c < 2)) begin errors++; $display("FAIL pr_wr_rd_gnt c%0d: got %b", c, pr_gnt); end
            checks++; if (mem_en !== (c < 2)) begin errors++; $display("FAIL pr_wr_rd_en c%0d: got %b", c, mem_en); end
            if (c == 0) begin
                checks++; if ({mem_we, mem_wdata} !== {1'b1, 8'h12}) begin errors++; $display("FAIL pr_write: got we=%b d=%h", mem_we, mem_wdata); end
            end
            checks++; if (pr_rvalid !== (c == 1 + L)) begin errors++; $display("FAIL pr_wr_rd_rvalid c%0d: got %b", c, pr_rvalid); end
            if (c == 1 + L) begin
                checks++; if (pr_rdata !== 8'h12) begin errors++; $display("FAIL pr_wr_rd_data: got %h want 12", pr_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        pr_req = 1'b1; pr_we = 1'b0; pr_addr = 12'h123;
        @(negedge clk);
        checks++; if (pr_gnt !== 1'b1) begin errors++; $display("FAIL midrst_pr_gnt: got %b want 1", pr_gnt); end
        tick();
        pr_req = 1'b0; sp_req = 1'b1; sp_addr = 12'h456;
        @(negedge clk);
        checks++; if (sp_gnt !== 1'b1) begin errors++; $display("FAIL midrst_sp_gnt: got %b want 1", sp_gnt); end
        tick();
        idle();
        rst_n = 1'b0; model_reset();
        @(negedge clk);
        checks++; if ({ld_gnt, pr_gnt, sp_gnt, pr_rvalid, sp_rvalid, mem_en, mem_we} !== 7'b0) begin errors++; $display("FAIL midrst_ctl: got %b want 0", {ld_gnt, pr_gnt, sp_gnt, pr_rvalid, sp_rvalid, mem_en, mem_we}); end
        checks++; if ({pr_rdata, sp_rdata, mem_addr, mem_wdata} !== 36'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", {pr_rdata, sp_rdata, mem_addr, mem_wdata}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < L + 2; k++) begin
            @(negedge clk);
            checks++; if ({pr_rvalid, sp_rvalid} !== 2'b00) begin errors++; $display("FAIL midrst_stale_rvalid k%0d: got %b want 00", k, {pr_rvalid, sp_rvalid}); end
            tick();
        end
    endtask

    task automatic test_contend();
        int n_pr, n_sp;
        logic [1:0] want;
        n_pr = 0; n_sp = 0;
        pr_req = 1'b1; pr_we = 1'b0; pr_addr = 12'h0A0;
        sp_req = 1'b1; sp_addr = 12'h0B0;
        for (int c = 0; c < 8 + L + 1; c++) begin
            if (c == 8) idle();
            @(negedge clk);
            model_expect();
`ifdef CHIP8_ARB_RR_EN
            want = (c >= 8) ? 2'b00 : ((c % 2 == 0) ? 2'b10 : 2'b01);
`else
            want = (c >= 8) ? 2'b00 : 2'b10;
`endif
            checks++; if ({pr_gnt, sp_gnt} !== want) begin errors++; $display("FAIL contend_gnt c%0d: got %b want %b", c, {pr_gnt, sp_gnt}, want); end
            checks++; if ({pr_rvalid, sp_rvalid} !== {exp_pr_rv, exp_sp_rv}) begin errors++; $display("FAIL contend_rvalid c%0d: got %b want %b", c, {pr_rvalid, sp_rvalid}, {exp_pr_rv, exp_sp_rv}); end
            checks++; if ({pr_rdata, sp_rdata} !== {exp_pr_rd, exp_sp_rd}) begin errors++; $display("FAIL contend_rdata c%0d: got %h want %h", c, {pr_rdata, sp_rdata}, {exp_pr_rd, exp_sp_rd}); end
            if (pr_gnt === 1'b1) n_pr++;
            if (sp_gnt === 1'b1) n_sp++;
            tick();
        end
`ifdef CHIP8_ARB_RR_EN
        checks++; if (n_pr != 4 || n_sp != 4) begin errors++; $display("FAIL contend_counts: got pr=%0d sp=%0d want 4/4", n_pr, n_sp); end
`else
        checks++; if (n_pr != 8 || n_sp != 0) begin errors++; $display("FAIL contend_counts: got pr=%0d sp=%0d want 8/0", n_pr, n_sp); end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  g;
        logic [11:0] wa;
        logic        wwe;
        for (int c = 0; c < 400 + L + 1; c++) begin
            if (c < 400) begin
                if (!ld_req && $urandom_range(0, 5) == 0) begin ld_req = 1'b1; ld_addr = rand_addr(); ld_wdata = 8'($urandom); end
                if (!pr_req && $urandom_range(0, 2) != 0) begin pr_req = 1'b1; pr_we = 1'($urandom_range(0, 1)); pr_addr = rand_addr(); pr_wdata = 8'($urandom); end
                if (!sp_req && $urandom_range(0, 1) == 0) begin sp_req = 1'b1; sp_addr = rand_addr(); end
            end else begin
                idle();
            end
            @(negedge clk);
            model_expect();
            g   = exp_gnt;
            wa  = g[2] ? ld_addr : (g[1] ? pr_addr : sp_addr);
            wwe = g[2] || (g[1] && pr_we);
            checks++; if ({ld_gnt, pr_gnt, sp_gnt} !== g) begin errors++; $display("FAIL rand_gnt c%0d: got %b want %b", c, {ld_gnt, pr_gnt, sp_gnt}, g); end
            checks++; if ({pr_rvalid, sp_rvalid} !== {exp_pr_rv, exp_sp_rv}) begin errors++; $display("FAIL rand_rvalid c%0d: got %b want %b", c, {pr_rvalid, sp_rvalid}, {exp_pr_rv, exp_sp_rv}); end
            checks++; if (pr_rdata !== exp_pr_rd) begin errors++; $display("FAIL rand_pr_rdata c%0d: got %h want %h", c, pr_rdata, exp_pr_rd); end
            checks++; if (sp_rdata !== exp_sp_rd) begin errors++; $display("FAIL rand_sp_rdata c%0d: got %h want %h", c, sp_rdata, exp_sp_rd); end
            checks++; if (mem_en !== (g != 3'b000)) begin errors++; $display("FAIL rand_mem_en c%0d: got %b want %b", c, mem_en, g != 3'b000); end
            if (g != 3'b000) begin
                checks++; if ({mem_we, mem_addr} !== {wwe, wa}) begin errors++; $display("FAIL rand_mem_access c%0d: got we=%b a=%h want we=%b a=%h", c, mem_we, mem_addr, wwe, wa); end
            end
            tick();
            if (g[2]) ld_req = 1'b0;
            if (g[1]) pr_req = 1'b0;
            if (g[0]) sp_req = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        pr_req = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wdata = '0;
        sp_req = 1'b0; sp_addr = '0;
        for (int i = 0; i < 4096; i++) shadow[i] = init_byte(12'(i));
        #2;
        test_reset();
        test_three_way();
        test_ld_pr();
        test_sp_burst();
        test_pr_wr_rd();
        test_reset_midstream();
        test_contend();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1);
    end

endmodule
